tetris_playfield_engine: RTL
============================

// Module: tetris_playfield_engine
// PURPOSE
//  Parametrised Tetris playfield core. Owns the static-cell grid, the falling piece (7 tetrominoes
//  with 4 rotations), gravity, key moves, locking, multi-line clear and game-over/restart.
//  It answers per-pixel occupancy queries from the VGA address decoder with registered outputs,
//  which feed the colour muxes ahead of the bgr output latch.
// PARAMETERS
//  COLS        10          playfield width in cells (4..16)
//  ROWS        20          playfield height in cells (4..32)
//  CELL_LOG2   4           cell size = 2**CELL_LOG2 pixels
//  ORIGIN_X    240         pixel x of the playfield left edge
//  ORIGIN_Y    80          pixel y of the playfield top edge
//  DROP_TICKS  10_000_000  clocks per gravity step (>=2)
//  SPAWN_COL   3           column of the piece's 4x4 box at spawn; spawn row = 0
// PORTS
//  iVGA_CLK      in   1   pixel clock; all logic rising-edge
//  iRST_n        in   1   async active-low reset
//  key_code      in   8   PS/2 make code; valid when key_en=1
//  key_en        in   1   one-cycle key strobe
//  rand_in       in   3   random source; piece = (rand_in==7) ? 0 : rand_in
//  pix_x, pix_y  in   10  pixel coordinates being drawn
//  cell_fill     out  1   pixel lies in an occupied cell (static or falling)
//  cell_edge     out  1   pixel is on the outer pixel ring of an occupied cell
//  game_over     out  1   high in state OVER
//  points_valid  out  1   one-cycle pulse when lines_cleared is valid
//  lines_cleared out  3   lines removed by the last lock (1..4); held until the next pulse
//  piece_type    out  3   current falling piece (0..6)
// BEHAVIOUR
//  Reset: grid all 0; state SPAWN; tick counter 0; piece_type 0; rot 0.
//   All outputs 0 until the first register update after reset is released.
//  Piece: type + rot (2b) index a 4x4 mask; position is (px, py) of the box's top-left cell.
//   px and py are signed so the box can overhang the field.
//  Collision (combinational): any mask bit outside 0..COLS-1 / 0..ROWS-1 or on a set grid cell.
//  States and transitions:
//   SPAWN: latch type from rand_in, rot=0, px=SPAWN_COL, py=0; clear tick counter.
//    Collision -> OVER, else -> FALL. Takes 1 cycle.
//   FALL: the tick counter counts 0..DROP_TICKS-1; tick = counter at DROP_TICKS-1, then wraps.
//    On tick: move down if free, else -> LOCK.
//    Keys, when there is no tick this cycle:
//     8'h6B: left, if free.
//     8'h74: right, if free.
//     8'h72: down, if free; else -> LOCK.
//     8'h75: rotate rot+1 mod 4, if free. No wall kicks.
//    Blocked moves are silently dropped.
//    A tick and a key in the same cycle: the tick wins and the key is discarded.
//   LOCK: OR the piece's cells into the grid in 1 cycle; clear the line counter; row pointer r=ROWS-1; -> CLEAR.
//   CLEAR: one row examined per cycle, bottom-up.
//    Full row: rows r..1 take rows r-1..0 and row 0 becomes 0, all in the same cycle;
//     line counter +1; r is re-examined next cycle.
//    Otherwise: r-1.
//    After r=0 is examined and is not full: if counter>0, pulse points_valid and load
//     lines_cleared in that cycle; -> SPAWN.
//    Counter saturates at 4.
//   OVER: grid and piece frozen; key 8'h29 clears the grid (1 cycle) -> SPAWN.
//    All other keys are ignored.
//  Keys arriving in SPAWN, LOCK or CLEAR are dropped. There is no key queue.
//  Pixel query:
//   cx = (pix_x-ORIGIN_X)>>CELL_LOG2, cy = (pix_y-ORIGIN_Y)>>CELL_LOG2.
//   Pixels outside the field give 0.
//   cell_fill = grid[cy][cx] | falling-piece cell.
//   cell_edge = cell_fill & (low CELL_LOG2 bits of x or y are all-0 or all-1).
//   Registered: 1-cycle latency from pix_x/pix_y.
//   The falling piece is not shown in OVER; the grid is still shown.
//  Reset mid-operation (any state, including mid-CLEAR shift) returns to the reset state in full.
// TESTING  (bench uses DROP_TICKS=8, COLS=10, ROWS=20)
//  Reset, rand_in=0 (I piece), no keys:
//   the piece falls 1 row every 8 clocks; locks after reaching the bottom; next SPAWN follows;
//   no points_valid.
//  Hold a key at the wall: 8'h6B x5 with rand_in=1 and the box at col 3:
//   px stops at the first collision; no grid change; no X on any output.
//  Pre-load rows 19 and 18 full except col 9; drop a vertical I into col 9:
//   one points_valid pulse with lines_cleared=2; rows 19/18 take the shifted contents; row 0 = 0.
//  Same-cycle tick and 8'h74 strobe:
//   only the down move happens; px unchanged.
//  Fill the spawn rows (0-1, cols 3-6):
//   the next SPAWN enters OVER and game_over=1; then 8'h29 gives a cleared grid, SPAWN,
//   and game_over=0 on the next cycle.
//  Pixel query: a static cell at (cx=0, cy=19), pix=(240, 384):
//   cell_fill=cell_edge=1 one cycle later; pix=(247, 391) gives fill=1, edge=0; pix=(239, 384) gives 0.

Source files
------------

// File: rtl/tetris_playfield_engine.sv
// Tetris playfield core: static grid, falling tetromino, gravity/keys, lock, multi-line clear, game over.
// Pixel occupancy (cell_fill/cell_edge) is registered one cycle after pix_x/pix_y; keys outside FALL/OVER are dropped.
module tetris_playfield_engine #(
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int CELL_LOG2  = 4,
  parameter int ORIGIN_X   = 240,
  parameter int ORIGIN_Y   = 80,
  parameter int DROP_TICKS = 10_000_000,
  parameter int SPAWN_COL  = 3
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [7:0] key_code,
  input  logic       key_en,
  input  logic [2:0] rand_in,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       cell_fill,
  output logic       cell_edge,
  output logic       game_over,
  output logic       points_valid,
  output logic [2:0] lines_cleared,
  output logic [2:0] piece_type
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(DROP_TICKS);

  typedef logic signed [6:0] pos_t;
  typedef logic [ROWS-1:0][COLS-1:0] grid_t;
  typedef enum logic [2:0] {
    S_SPAWN = 3'd0,
    S_FALL  = 3'd1,
    S_LOCK  = 3'd2,
    S_CLEAR = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t        state;
  grid_t         grid;
  grid_t         piece_map;
  logic [1:0]    rot;
  pos_t          px;
  pos_t          py;
  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] row_ptr;
  logic [2:0]    line_cnt;
  logic [2:0]    spawn_type;
  logic [15:0]   cur_mask;
  logic          tick;
  logic          hit_spawn, hit_left, hit_right, hit_down, hit_rot;
  logic          show_piece;
  logic          fill_c, edge_c;

  // Mask bit for box cell (row r, col c) is m[15 - 4*r - c]; literals read row 0 first, col 0 leftmost.
  function automatic logic [15:0] piece_mask(input logic [2:0] t, input logic [1:0] r);
    logic [15:0] m;
    m = '0;
    case (t)
      3'd0: case (r)
        2'd0:    m = 16'b0000_1111_0000_0000;
        2'd1:    m = 16'b0010_0010_0010_0010;
        2'd2:    m = 16'b0000_0000_1111_0000;
        default: m = 16'b0100_0100_0100_0100;
      endcase
      3'd1: m = 16'b0110_0110_0000_0000;
      3'd2: case (r)
        2'd0:    m = 16'b0100_1110_0000_0000;
        2'd1:    m = 16'b0100_0110_0100_0000;
        2'd2:    m = 16'b0000_1110_0100_0000;
        default: m = 16'b0100_1100_0100_0000;
      endcase
      3'd3: case (r)
        2'd0:    m = 16'b0110_1100_0000_0000;
        2'd1:    m = 16'b0100_0110_0010_0000;
        2'd2:    m = 16'b0000_0110_1100_0000;
        default: m = 16'b1000_1100_0100_0000;
      endcase
      3'd4: case (r)
        2'd0:    m = 16'b1100_0110_0000_0000;
        2'd1:    m = 16'b0010_0110_0100_0000;
        2'd2:    m = 16'b0000_1100_0110_0000;
        default: m = 16'b0100_1100_1000_0000;
      endcase
      3'd5: case (r)
        2'd0:    m = 16'b1000_1110_0000_0000;
        2'd1:    m = 16'b0110_0100_0100_0000;
        2'd2:    m = 16'b0000_1110_0010_0000;
        default: m = 16'b0100_0100_1100_0000;
      endcase
      3'd6: case (r)
        2'd0:    m = 16'b0010_1110_0000_0000;
        2'd1:    m = 16'b0100_0100_0110_0000;
        2'd2:    m = 16'b0000_1110_1000_0000;
        default: m = 16'b1100_0100_0100_0000;
      endcase
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic collides(input grid_t g, input logic [15:0] m, input pos_t x, input pos_t y);
    logic hit;
    int   cx, cy;
    hit = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cx = int'(x) + c;
        cy = int'(y) + r;
        if (m[15-(r*4+c)]) begin
          if (cx < 0 || cx >= COLS || cy < 0 || cy >= ROWS) hit = 1'b1;
          else if (g[cy[RW-1:0]][cx[CW-1:0]]) hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

  always_comb begin
    spawn_type = (rand_in == 3'd7) ? 3'd0 : rand_in;
    cur_mask   = piece_mask(piece_type, rot);
    tick       = (tick_cnt == TW'(DROP_TICKS - 1));
    hit_spawn  = collides(grid, piece_mask(spawn_type, 2'd0), pos_t'(SPAWN_COL), pos_t'(0));
    hit_left   = collides(grid, cur_mask, px - pos_t'(1), py);
    hit_right  = collides(grid, cur_mask, px + pos_t'(1), py);
    hit_down   = collides(grid, cur_mask, px, py + pos_t'(1));
    hit_rot    = collides(grid, piece_mask(piece_type, rot + 2'd1), px, py);
  end

  // Falling piece rendered as a full-field bitmap; shared by locking and the pixel query.
  always_comb begin
    int cx, cy;
    piece_map = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cx = int'(px) + c;
        cy = int'(py) + r;
        if (cur_mask[15-(r*4+c)] && cx >= 0 && cx < COLS && cy >= 0 && cy < ROWS)
          piece_map[cy[RW-1:0]][cx[CW-1:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state         <= S_SPAWN;
      grid          <= '0;
      tick_cnt      <= '0;
      piece_type    <= '0;
      rot           <= '0;
      px            <= '0;
      py            <= '0;
      row_ptr       <= '0;
      line_cnt      <= '0;
      game_over     <= 1'b0;
      points_valid  <= 1'b0;
      lines_cleared <= '0;
    end else begin
      points_valid <= 1'b0;
      case (state)
        S_SPAWN: begin
          piece_type <= spawn_type;
          rot        <= '0;
          px         <= pos_t'(SPAWN_COL);
          py         <= '0;
          tick_cnt   <= '0;
          if (hit_spawn) begin
            state     <= S_OVER;
            game_over <= 1'b1;
          end else begin
            state <= S_FALL;
          end
        end
        S_FALL: begin
          if (tick) begin
            // Gravity has priority; any key strobe in this cycle is discarded.
            tick_cnt <= '0;
            if (hit_down) state <= S_LOCK;
            else          py    <= py + pos_t'(1);
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
            if (key_en) begin
              case (key_code)
                8'h6B: if (!hit_left)  px <= px - pos_t'(1);
                8'h74: if (!hit_right) px <= px + pos_t'(1);
                8'h72: begin
                  if (hit_down) state <= S_LOCK;
                  else          py    <= py + pos_t'(1);
                end
                8'h75: if (!hit_rot) rot <= rot + 2'd1;
                default: ;
              endcase
            end
          end
        end
        S_LOCK: begin
          grid     <= grid | piece_map;
          line_cnt <= '0;
          row_ptr  <= RW'(ROWS - 1);
          state    <= S_CLEAR;
        end
        S_CLEAR: begin
          if (&grid[row_ptr]) begin
            // Collapse everything above the full row; the same row is examined again next cycle.
            for (int i = 1; i < ROWS; i++)
              if (i <= int'(row_ptr)) grid[i] <= grid[i-1];
            grid[0] <= '0;
            if (line_cnt != 3'd4) line_cnt <= line_cnt + 3'd1;
          end else if (row_ptr == '0) begin
            if (line_cnt != 3'd0) begin
              points_valid  <= 1'b1;
              lines_cleared <= line_cnt;
            end
            state <= S_SPAWN;
          end else begin
            row_ptr <= row_ptr - 1'b1;
          end
        end
        S_OVER: begin
          if (key_en && key_code == 8'h29) begin
            grid      <= '0;
            game_over <= 1'b0;
            state     <= S_SPAWN;
          end
        end
        default: state <= S_SPAWN;
      endcase
    end
  end

  // After LOCK the piece lives in the grid, so it is only drawn while falling or about to merge.
  assign show_piece = (state == S_FALL) || (state == S_LOCK);

  always_comb begin
    int dx, dy, qx, qy;
    logic [CELL_LOG2-1:0] lx, ly;
    dx     = int'(pix_x) - ORIGIN_X;
    dy     = int'(pix_y) - ORIGIN_Y;
    qx     = dx >>> CELL_LOG2;
    qy     = dy >>> CELL_LOG2;
    lx     = dx[CELL_LOG2-1:0];
    ly     = dy[CELL_LOG2-1:0];
    fill_c = 1'b0;
    if (dx >= 0 && dy >= 0 && qx < COLS && qy < ROWS)
      fill_c = grid[qy[RW-1:0]][qx[CW-1:0]] |
               (show_piece & piece_map[qy[RW-1:0]][qx[CW-1:0]]);
    edge_c = fill_c & ((lx == '0) | (lx == '1) | (ly == '0) | (ly == '1));
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cell_fill <= 1'b0;
      cell_edge <= 1'b0;
    end else begin
      cell_fill <= fill_c;
      cell_edge <= edge_c;
    end
  end

endmodule
